// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: FSM encoding, initial hash value, round constants
// and the six bitwise mixing functions.
package sha256_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_ROUND  = 3'd2,
        ST_UPDATE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam logic [255:0] IV_ALL = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f,
                                       input logic [31:0] g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

    function automatic logic [31:0] k_const(input logic [5:0] t);
        logic [31:0] k;
        case (t)
            6'd0:  k = 32'h428a2f98; 6'd1:  k = 32'h71374491; 6'd2:  k = 32'hb5c0fbcf; 6'd3:  k = 32'he9b5dba5;
            6'd4:  k = 32'h3956c25b; 6'd5:  k = 32'h59f111f1; 6'd6:  k = 32'h923f82a4; 6'd7:  k = 32'hab1c5ed5;
            6'd8:  k = 32'hd807aa98; 6'd9:  k = 32'h12835b01; 6'd10: k = 32'h243185be; 6'd11: k = 32'h550c7dc3;
            6'd12: k = 32'h72be5d74; 6'd13: k = 32'h80deb1fe; 6'd14: k = 32'h9bdc06a7; 6'd15: k = 32'hc19bf174;
            6'd16: k = 32'he49b69c1; 6'd17: k = 32'hefbe4786; 6'd18: k = 32'h0fc19dc6; 6'd19: k = 32'h240ca1cc;
            6'd20: k = 32'h2de92c6f; 6'd21: k = 32'h4a7484aa; 6'd22: k = 32'h5cb0a9dc; 6'd23: k = 32'h76f988da;
            6'd24: k = 32'h983e5152; 6'd25: k = 32'ha831c66d; 6'd26: k = 32'hb00327c8; 6'd27: k = 32'hbf597fc7;
            6'd28: k = 32'hc6e00bf3; 6'd29: k = 32'hd5a79147; 6'd30: k = 32'h06ca6351; 6'd31: k = 32'h14292967;
            6'd32: k = 32'h27b70a85; 6'd33: k = 32'h2e1b2138; 6'd34: k = 32'h4d2c6dfc; 6'd35: k = 32'h53380d13;
            6'd36: k = 32'h650a7354; 6'd37: k = 32'h766a0abb; 6'd38: k = 32'h81c2c92e; 6'd39: k = 32'h92722c85;
            6'd40: k = 32'ha2bfe8a1; 6'd41: k = 32'ha81a664b; 6'd42: k = 32'hc24b8b70; 6'd43: k = 32'hc76c51a3;
            6'd44: k = 32'hd192e819; 6'd45: k = 32'hd6990624; 6'd46: k = 32'hf40e3585; 6'd47: k = 32'h106aa070;
            6'd48: k = 32'h19a4c116; 6'd49: k = 32'h1e376c08; 6'd50: k = 32'h2748774c; 6'd51: k = 32'h34b0bcb5;
            6'd52: k = 32'h391c0cb3; 6'd53: k = 32'h4ed8aa4a; 6'd54: k = 32'h5b9cca4f; 6'd55: k = 32'h682e6ff3;
            6'd56: k = 32'h748f82ee; 6'd57: k = 32'h78a5636f; 6'd58: k = 32'h84c87814; 6'd59: k = 32'h8cc70208;
            6'd60: k = 32'h90befffa; 6'd61: k = 32'ha4506ceb; 6'd62: k = 32'hbef9a3f7; 6'd63: k = 32'hc67178f2;
            default: k = 32'h00000000;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/sha256_reg32.sv
// 32-bit register with per-instance reset value, async active-low reset,
// synchronous soft reset to the same value, and load enable.
module sha256_reg32 #(
    parameter logic [31:0] RST_VAL = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        srst,
    input  logic        en,
    input  logic [31:0] d,
    output logic [31:0] q
);

    // Storage: soft reset has priority over load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RST_VAL;
        end else if (srst) begin
            q <= RST_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/sha256_w_sched.sv
// 16-word message window: shifts in message words while loading, then
// extends the schedule one word per round; W[t] is always the oldest entry.
module sha256_w_sched
    import sha256_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        srst,
    input  logic        load,
    input  logic        shift,
    input  logic [31:0] word_in,
    output logic [31:0] wt
);

    logic [31:0] win_r [16];
    logic [31:0] new_s;

    // Word entering the window: the incoming message word or W[t+16].
    always_comb begin
        new_s = 32'h00000000;
        if (load) begin
            new_s = word_in;
        end else begin
            new_s = ssig1(win_r[14]) + win_r[9] + ssig0(win_r[1]) + win_r[0];
        end
    end

    // Window storage, oldest word at index 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) win_r[i] <= 32'h00000000;
        end else if (srst) begin
            for (int i = 0; i < 16; i++) win_r[i] <= 32'h00000000;
        end else if (load || shift) begin
            for (int i = 0; i < 15; i++) win_r[i] <= win_r[i+1];
            win_r[15] <= new_s;
        end
    end

    assign wt = win_r[0];

endmodule

// File: rtl/sha256_round_ctrl.sv
// SHA-256 compression sequencer: takes 16 words per block, runs the rounds one
// per clock and folds the working variables into the chained hash state.
module sha256_round_ctrl
    import sha256_pkg::*;
#(
    parameter int ROUNDS = 64,
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init,
    input  logic              blk_valid,
    output logic              blk_ready,
    input  logic [WORD_W-1:0] word_in,
    output logic              busy,
    output logic              digest_valid,
    output logic [255:0]      digest
);

    state_t      state_r, state_nxt_s;
    logic [3:0]  wcnt_r;
    logic [5:0]  t_r;
    logic        dv_r;
    logic [31:0] a_r, b_r, c_r, d_r, e_r, f_r, g_r, h_r;
    logic [31:0] hq_s [8];
    logic [31:0] hd_s [8];
    logic [31:0] v_s  [8];
    logic [31:0] wt_s, t1_s, t2_s;
    logic        rst_n_s, ready_s, xfer_s, init_take_s, first_s, h_upd_s;

    assign rst_n_s     = reset;
    assign ready_s     = ((state_r == ST_IDLE) || (state_r == ST_LOAD) ||
                          (state_r == ST_DONE)) && !init;
    assign xfer_s      = blk_valid && ready_s;
    assign init_take_s = init && ((state_r == ST_IDLE) || (state_r == ST_DONE));
    assign first_s     = xfer_s && ((state_r == ST_IDLE) || (state_r == ST_DONE));
    assign h_upd_s     = (state_r == ST_UPDATE);

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (init_take_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (xfer_s) begin
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_LOAD: begin
                if (xfer_s && (wcnt_r == 4'd15)) begin
                    state_nxt_s = ST_ROUND;
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
            ST_ROUND: begin
                if (t_r == 6'(ROUNDS - 1)) begin
                    state_nxt_s = ST_UPDATE;
                end else begin
                    state_nxt_s = ST_ROUND;
                end
            end
            ST_UPDATE: state_nxt_s = ST_DONE;
            default:   state_nxt_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Word and round counters; t holds at its last value instead of wrapping.
    always_ff @(posedge clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            wcnt_r <= 4'd0;
            t_r    <= 6'd0;
        end else if (init_take_s) begin
            wcnt_r <= 4'd0;
            t_r    <= 6'd0;
        end else if (first_s) begin
            wcnt_r <= 4'd1;
            t_r    <= 6'd0;
        end else if ((state_r == ST_LOAD) && xfer_s) begin
            wcnt_r <= wcnt_r + 4'd1;
            t_r    <= 6'd0;
        end else if ((state_r == ST_ROUND) && (t_r != 6'(ROUNDS - 1))) begin
            t_r    <= t_r + 6'd1;
        end
    end

    sha256_w_sched u_w_sched (
        .clk     (clk),
        .rst_n   (rst_n_s),
        .srst    (init_take_s),
        .load    (xfer_s),
        .shift   (state_r == ST_ROUND),
        .word_in (word_in[31:0]),
        .wt      (wt_s)
    );

    assign t1_s = h_r + bsig1(e_r) + ch(e_r, f_r, g_r) + k_const(t_r) + wt_s;
    assign t2_s = bsig0(a_r) + maj(a_r, b_r, c_r);

    // Working variables: seeded from H at the first word, one round per cycle after.
    always_ff @(posedge clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            {a_r, b_r, c_r, d_r, e_r, f_r, g_r, h_r} <= 256'h0;
        end else if (first_s) begin
            {a_r, b_r, c_r, d_r} <= {hq_s[0], hq_s[1], hq_s[2], hq_s[3]};
            {e_r, f_r, g_r, h_r} <= {hq_s[4], hq_s[5], hq_s[6], hq_s[7]};
        end else if (state_r == ST_ROUND) begin
            {a_r, b_r, c_r, d_r} <= {t1_s + t2_s, a_r, b_r, c_r};
            {e_r, f_r, g_r, h_r} <= {d_r + t1_s, e_r, f_r, g_r};
        end
    end

    assign v_s[0] = a_r; assign v_s[1] = b_r; assign v_s[2] = c_r; assign v_s[3] = d_r;
    assign v_s[4] = e_r; assign v_s[5] = f_r; assign v_s[6] = g_r; assign v_s[7] = h_r;

    for (genvar i = 0; i < 8; i++) begin : g_hreg
        assign hd_s[i] = hq_s[i] + v_s[i];
        sha256_reg32 #(.RST_VAL(IV_ALL[255-32*i -: 32])) u_h (
            .clk   (clk),
            .rst_n (rst_n_s),
            .srst  (init_take_s),
            .en    (h_upd_s),
            .d     (hd_s[i]),
            .q     (hq_s[i])
        );
    end

    // Digest-valid flag: rises one cycle into DONE, drops on init or a new block.
    always_ff @(posedge clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            dv_r <= 1'b0;
        end else if (init_take_s || xfer_s) begin
            dv_r <= 1'b0;
        end else if (state_r == ST_DONE) begin
            dv_r <= 1'b1;
        end
    end

    assign blk_ready    = ready_s;
    assign busy         = (state_r == ST_LOAD) || (state_r == ST_ROUND) ||
                          (state_r == ST_UPDATE);
    assign digest_valid = dv_r;
    assign digest       = {hq_s[0], hq_s[1], hq_s[2], hq_s[3],
                           hq_s[4], hq_s[5], hq_s[6], hq_s[7]};

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Self-checking bench: table of message blocks with expected digests queued in
// a scoreboard, plus hand sequences for init and mid-block reset.
module tb_sha256_round_ctrl;

    logic         clk = 1'b0;
    logic         reset;
    logic         init;
    logic         blk_valid;
    logic         blk_ready;
    logic [31:0]  word_in;
    logic         busy;
    logic         digest_valid;
    logic [255:0] digest;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n15 = 0;

    localparam logic [255:0] IV  = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] EMP = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] TWO = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    typedef struct {
        logic [15:0][31:0] w;
        bit                last;
        bit                gaps;
        int                init_at;
        logic [255:0]      exp;
    } vec_t;

    vec_t tab [4];
    logic [255:0] exp_q [$];

    sha256_round_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .init         (init),
        .blk_valid    (blk_valid),
        .blk_ready    (blk_ready),
        .word_in      (word_in),
        .busy         (busy),
        .digest_valid (digest_valid),
        .digest       (digest)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pulse_init();
        init = 1'b1;
        @(posedge clk); #1;
        init = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit gaps);
        bit done = 1'b0;
        bit rdy;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                blk_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        blk_valid = 1'b1;
        word_in   = w;
        for (int k = 0; k < 300 && !done; k++) begin
            @(negedge clk);
            rdy = blk_ready;
            @(posedge clk); #1;
            if (rdy) done = 1'b1;
        end
        blk_valid = 1'b0;
        if (!done) begin
            checks++; errors++;
            $display("FAIL send_word: no transfer of %h within 300 cycles", w);
        end
    endtask

    task automatic send_block(input logic [15:0][31:0] w, input bit gaps);
        for (int j = 0; j < 16; j++) send_word(w[j], gaps);
        n15 = cyc;
    endtask

    // Waits for digest_valid after W15; checks latency, handshake idling and result.
    task automatic wait_digest(input string name, input int init_at);
        int  lat = -1;
        bit  seen = 1'b0;
        bit  rdy_bad = 1'b0;
        bit  dv_early = 1'b0;
        logic [255:0] exp;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            lat = cyc - n15;
            if (init_at >= 0 && lat == init_at) init = 1'b1;
            else init = 1'b0;
            if (lat <= 64 && (blk_ready || !busy)) rdy_bad = 1'b1;
            if (digest_valid) begin
                seen = 1'b1;
                if (lat < 66) dv_early = 1'b1;
            end
        end
        init = 1'b0;
        chk({name, " latency"}, 256'(lat), 256'(66));
        chk({name, " ready_low_in_round"}, 256'(rdy_bad), 256'(0));
        chk({name, " dv_not_early"}, 256'(dv_early), 256'(0));
        if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s: scoreboard empty, got %h", name, digest);
        end else begin
            exp = exp_q.pop_front();
            chk({name, " digest"}, digest, exp);
        end
    endtask

    initial begin
        bit msg_start = 1'b1;

        reset = 1'b0; init = 1'b0; blk_valid = 1'b0; word_in = 32'h0;

        tab[0].w = '0; tab[0].w[0] = 32'h61626380; tab[0].w[15] = 32'h00000018;
        tab[0].last = 1'b1; tab[0].gaps = 1'b0; tab[0].init_at = 10; tab[0].exp = ABC;
        tab[1].w = '0; tab[1].w[0] = 32'h80000000;
        tab[1].last = 1'b1; tab[1].gaps = 1'b0; tab[1].init_at = -1; tab[1].exp = EMP;
        tab[2].w = {32'h00000000, 32'h80000000, 32'h6e6f7071, 32'h6d6e6f70,
                    32'h6c6d6e6f, 32'h6b6c6d6e, 32'h6a6b6c6d, 32'h696a6b6c,
                    32'h68696a6b, 32'h6768696a, 32'h66676869, 32'h65666768,
                    32'h64656667, 32'h63646566, 32'h62636465, 32'h61626364};
        tab[2].last = 1'b0; tab[2].gaps = 1'b1; tab[2].init_at = -1; tab[2].exp = '0;
        tab[3].w = '0; tab[3].w[15] = 32'h000001c0;
        tab[3].last = 1'b1; tab[3].gaps = 1'b1; tab[3].init_at = -1; tab[3].exp = TWO;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset digest", digest, IV);
        chk("reset digest_valid", 256'(digest_valid), 256'(0));
        chk("reset busy", 256'(busy), 256'(0));
        chk("reset blk_ready", 256'(blk_ready), 256'(1));
        reset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 4; i++) begin
            if (msg_start && i != 0) pulse_init();
            if (tab[i].last) exp_q.push_back(tab[i].exp);
            send_block(tab[i].w, tab[i].gaps);
            if (tab[i].last) wait_digest($sformatf("vec%0d", i), tab[i].init_at);
            msg_start = tab[i].last;
        end

        // init together with blk_valid in DONE: init wins, nothing transfers
        @(negedge clk);
        init = 1'b1; blk_valid = 1'b1; word_in = 32'h61626380;
        #1;
        chk("init_valid blk_ready", 256'(blk_ready), 256'(0));
        @(posedge clk); #1;
        init = 1'b0; blk_valid = 1'b0;
        @(negedge clk);
        chk("init_valid digest", digest, IV);
        chk("init_valid digest_valid", 256'(digest_valid), 256'(0));
        chk("init_valid busy", 256'(busy), 256'(0));

        // reset at round 30 of "abc", then resend
        send_block(tab[0].w, 1'b0);
        while (cyc - n15 < 30) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midreset digest", digest, IV);
        chk("midreset digest_valid", 256'(digest_valid), 256'(0));
        chk("midreset busy", 256'(busy), 256'(0));
        chk("midreset blk_ready", 256'(blk_ready), 256'(1));
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        exp_q.push_back(ABC);
        send_block(tab[0].w, 1'b0);
        wait_digest("abc_after_reset", -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sha256_round_ctrl.md
Name: sha256_round_ctrl

Overview:
Sequences one SHA-256 compression per 512-bit message block. It accepts 16 big-endian message words over a valid/ready stream and runs 64 rounds, one per clock, over working variables a..h. It then folds the result into the eight hash-state words H0..H7, which it also initialises to the SHA-256 IV. It sits between the message padder upstream and the digest consumer downstream, and owns all round sequencing in the hash core.

Parameters:
ROUNDS, 64, compression rounds per block; fixed by the standard and exposed only for reduced-round debug builds (legal: 16..64).
WORD_W, 32, datapath word width; only 32 is supported.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
init  input  1  single-cycle pulse: reload H0..H7 with the IV before a new message.
blk_valid  input  1  word_in is valid.
blk_ready  output  1  controller accepts word_in this cycle.
word_in  input  32  message word; words arrive in order W0..W15.
busy  output  1  high in LOAD, ROUND and UPDATE.
digest_valid  output  1  digest holds the hash of all blocks absorbed since the last init.
digest  output  256  {H0,H1,...,H7}, with H0 in bits [255:224].

Behaviour:
- Reset (reset=0, async) sets: state=IDLE; H0..H7=IV (6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19); digest_valid=0; busy=0; counters=0. blk_ready is combinational and reads 1 after reset while init=0.
- Reset mid-block aborts the block; no partial update of H is ever visible.
- States:
  - IDLE: waiting for the first word.
  - LOAD: accepting W0..W15.
  - ROUND: running rounds t=0..ROUNDS-1.
  - UPDATE: one cycle that folds a..h into H.
  - DONE: digest available.
- blk_ready = (state in IDLE, LOAD, DONE) && !init. A word transfers on the rising edge where blk_valid && blk_ready.
- IDLE/DONE with a transfer: store W0, load a..h from H0..H7, go to LOAD with wcnt=1, clear digest_valid.
- LOAD: each transfer stores a word and increments the 4-bit wcnt. The transfer of W15 (wcnt=15) moves to ROUND with t=0. Gaps (blk_valid=0) stall without limit.
- ROUND: one round per cycle.
  - T1 = h + Σ1(e) + Ch(e,f,g) + K[t] + W[t].
  - T2 = Σ0(a) + Maj(a,b,c).
  - Shift: a←T1+T2, e←d+T1, and b..d, f..h shift down.
  - All additions are modulo 2^32; carries are discarded.
- W[t] for t≥16 comes from the 16-word sliding window: σ1(W[t-2]) + W[t-7] + σ0(W[t-15]) + W[t-16]. The window shifts once per round.
- At t=ROUNDS-1 the state goes to UPDATE. t is a 6-bit counter and never wraps within a block.
- UPDATE: Hi ← Hi + {a..h}[i] mod 2^32, then go to DONE.
- DONE: digest_valid=1.
- Latency: W15 accepted at edge N → rounds on edges N+1..N+64 → H updated at edge N+65 → digest_valid=1 from N+66. Total is 66 cycles per block from the last word.
- Multi-block: a new W0 accepted in DONE starts the next block using the current H (chaining). digest_valid drops on that same edge.
- init: honoured only in IDLE/DONE. It sets H=IV, digest_valid=0 and state=IDLE. It is ignored while busy=1. init and blk_valid in the same cycle: init wins and no word transfers.
- blk_valid while blk_ready=0: the word is not consumed. The upstream holds word_in stable until the transfer.

Decomposition:
- Shared package sha256_pkg holds:
  - K[0..63] constant table.
  - IV[0..7].
  - FSM state encoding: IDLE, LOAD, ROUND, UPDATE, DONE.
  - Functions Σ0, Σ1, σ0, σ1, Ch and Maj.
- One natural sub-module, sha256_w_sched: the 16×32 message window. It has load/shift enables and outputs W[t]. It is instantiated once.
- H0..H7 are eight instances of the team's 32-bit register with per-word default values. They need an active-low reset adapter and a load enable.

Test Plan:
- "abc" (W0=61626380, W1..W14=0, W15=00000018) → digest = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad, with digest_valid exactly 66 cycles after W15.
- Empty message (W0=80000000, rest 0) → e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", with random blk_valid gaps → 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1. blk_ready=0 throughout ROUND/UPDATE.
- init pulsed during ROUND → ignored and the block completes correctly. init with blk_valid in DONE → no transfer; H returns to IV; digest_valid=0.
- reset asserted at round 30 of "abc" → outputs return to reset values immediately. Re-sending "abc" yields the correct digest.
